// File: rtl/muldiv_iter.sv
// Iterative multiply/divide unit: one shift-add or restoring shift-subtract step per cycle.
// Signed operations run on magnitudes; signs are restored when the result is loaded.
module muldiv_iter #(
    parameter int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic             ready,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic               is_div_q, neg_lo_q, neg_hi_q, b_zero_q;
    logic [WIDTH-1:0]   acc_hi, acc_lo, opnd_m;

    logic               is_signed, is_div, a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum, div_shift, div_diff;
    logic [WIDTH-1:0]   nxt_hi, nxt_lo, res_hi, res_lo;
    logic [2*WIDTH-1:0] prod_fix;

    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] x, input logic neg);
        logic signed [WIDTH-1:0] xs;
        xs = x;
        return neg ? -xs : xs;
    endfunction

    function automatic logic [2*WIDTH-1:0] cond_neg2(input logic [2*WIDTH-1:0] x, input logic neg);
        logic signed [2*WIDTH-1:0] xs;
        xs = x;
        return neg ? -xs : xs;
    endfunction

    assign is_signed = ~op[0];
    assign is_div    = op[1];
    assign a_neg     = is_signed & a[WIDTH-1];
    assign b_neg     = is_signed & b[WIDTH-1];
    assign a_mag     = cond_neg(a, a_neg);
    assign b_mag     = cond_neg(b, b_neg);

    // Iteration step: acc_lo holds the multiplier (mult) or the dividend/quotient (div)
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd_m} : '0);
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd_m};
        if (is_div_q) begin
            nxt_hi = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
            nxt_lo = {acc_lo[WIDTH-2:0], ~div_diff[WIDTH]};
        end else begin
            nxt_hi = mul_sum[WIDTH:1];
            nxt_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
        end
        prod_fix = cond_neg2({nxt_hi, nxt_lo}, neg_lo_q);
        if (is_div_q) begin
            // A zero divisor leaves the dividend in the remainder, so hi naturally equals a
            res_hi = cond_neg(nxt_hi, neg_hi_q);
            res_lo = b_zero_q ? '1 : cond_neg(nxt_lo, neg_lo_q);
        end else begin
            res_hi = prod_fix[2*WIDTH-1:WIDTH];
            res_lo = prod_fix[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            hi       <= '0;
            lo       <= '0;
            div_zero <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && start && !cancel) begin
                cnt      <= CNT_W'(WIDTH);
                is_div_q <= is_div;
                neg_lo_q <= a_neg ^ b_neg;
                neg_hi_q <= a_neg;
                b_zero_q <= is_div & (b == '0);
                acc_hi   <= '0;
                acc_lo   <= a_mag;
                opnd_m   <= b_mag;
            end else if (state == S_RUN && !cancel) begin
                cnt    <= cnt - CNT_W'(1);
                acc_hi <= nxt_hi;
                acc_lo <= nxt_lo;
                if (cnt == CNT_W'(1)) begin
                    hi       <= res_hi;
                    lo       <= res_lo;
                    div_zero <= b_zero_q;
                end
            end
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = (state != S_IDLE);
        ready     = (state == S_DONE);
        case (state)
            S_IDLE:  if (start && !cancel) state_nxt = S_RUN;
            S_RUN: begin
                if (cancel)                  state_nxt = S_IDLE;
                else if (cnt == CNT_W'(1))   state_nxt = S_DONE;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: doc/muldiv_iter.md
Name: muldiv_iter

Overview:
- Parametrised iterative multiply/divide unit for the execute stage.
- Computes signed and unsigned multiply and divide one bit per cycle, with a start/busy/ready handshake so the hazard unit can stall the pipeline while it works.
- Produces full-width HI/LO results for the HI/LO register writeback.
- Adds what the current ALU path lacks: width generalisation, a cancel input for pipeline flush, and divide-by-zero reporting.

Parameters:
- WIDTH, 32, operand width; results are WIDTH each for hi and lo; must be even and >= 4.
- CNT_W, $clog2(WIDTH+1), iteration counter width; derived, not overridden.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous active-high reset.
- start  input  1  request; sampled only in IDLE.
- op  input  2  operation: 00 mult, 01 multu, 10 div, 11 divu; sampled with start.
- a  input  WIDTH  multiplicand / dividend; sampled with start.
- b  input  WIDTH  multiplier / divisor; sampled with start.
- cancel  input  1  abort the in-flight operation (pipeline flush).
- busy  output  1  high from the cycle after start is accepted through the DONE cycle.
- ready  output  1  single-cycle pulse; hi, lo and div_zero are valid in this cycle.
- hi  output  WIDTH  mult: upper product half; div: remainder.
- lo  output  WIDTH  mult: lower product half; div: quotient.
- div_zero  output  1  high with the result of a div/divu whose b==0; held with hi/lo.

Behaviour:
- Reset (rst=1 at an edge, any state): state=IDLE, busy=0, ready=0, hi=0, lo=0, div_zero=0, counter=0. Applies mid-operation; the in-flight operation is discarded.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 and cancel=0 → latch op, |a| and |b| (magnitudes only when op is signed) and the result signs; counter=WIDTH; go to RUN.
  - start=1 and cancel=1 → start dropped, stay in IDLE.
- RUN, one iteration per cycle, counter decrements:
  - mult: shift-add.
  - div: restoring shift-subtract.
  - Transition: counter reaches 0 → go to DONE; at that edge apply sign correction and load hi/lo/div_zero.
- DONE: ready=1, busy=1 for exactly one cycle → IDLE.
- Latency: start high in cycle 0 → busy cycles 1..WIDTH+1 → ready in cycle WIDTH+1 (cycle 33 for WIDTH=32). Earliest next accepted start is cycle WIDTH+2.
- start while busy=1 (RUN or DONE): ignored, with no queuing.
- cancel in RUN: next edge → IDLE; busy=0; no ready. hi/lo/div_zero keep their previous completed values.
- cancel in DONE: ignored; the result has already been delivered.
- Signed mult: product sign = sign(a) XOR sign(b), applied as a 2*WIDTH two's-complement negate.
- Signed div:
  - quotient sign = sign(a) XOR sign(b); remainder takes the sign of the dividend.
  - Invariant: a == lo*b + hi.
- Overflow case: most-negative / -1 (signed) → lo=most-negative (wraps), hi=0, div_zero=0.
- Divide by zero (div or divu, b==0):
  - Same latency as any other operation.
  - Result: hi=a (raw input), lo=all ones, div_zero=1.
- div_zero is cleared at the DONE entry of any operation without a zero divisor.
- hi/lo/div_zero change only at DONE entry or reset; they are stable at all other times.
- ready never asserts in two consecutive cycles.

Test Plan:
- mult: a=0xFFFFFFFD, b=0x00000005, start in cycle 0 → ready only in cycle 33; hi=0xFFFFFFFF, lo=0xFFFFFFF1; busy high in cycles 1..33.
- multu: a=b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. Then back-to-back start in cycle 34 is accepted; a start pulsed in cycle 20 is ignored.
- div: a=0xFFFFFFF9 (-7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu: a=7, b=2 → lo=3, hi=1, div_zero=0.
- divu: a=0x00001234, b=0 → ready in cycle 33; hi=0x00001234, lo=0xFFFFFFFF, div_zero=1. A following divu 10/3 clears div_zero (lo=3, hi=1).
- cancel=1 in cycle 10 of a mult → busy=0 from cycle 11; ready never pulses; hi/lo keep the prior values.
- start together with cancel in IDLE → no busy.
- rst=1 in cycle 15 of a div → all outputs 0 from the next cycle.
- Signed 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- WIDTH=8 build, mult a=0x80, b=0x80 → hi=0x40, lo=0x00; ready in cycle 9.
